lab2_fir_xpose: RTL and testbench

Transposed-form 4-tap FIR filter with valid/ready streaming on input and output and a writable coefficient register file. It computes the same unsigned, truncated-to-DATA_W response as the team's direct-form 4-tap FIR: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] + b3·x[n-3]. The tap chain runs the other way: partial sums move toward the output, not samples toward the multipliers. It sits between an upstream sample source and a downstream consumer, either of which may stall.

---
 rtl/lab2_fir_pkg.sv | 23 ++
 rtl/lab2_fir_coef_rf.sv | 34 +++
 rtl/lab2_fir_xpose.sv | 92 +++++++++
 tb/tb_lab2_fir_xpose.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lab2_fir_pkg.sv
// Shared widths, types and a direct-form reference model for the 4-tap FIR.
package lab2_fir_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 8;
  localparam int NTAPS  = 4;
  localparam int ACC_W  = DATA_W + COEF_W + 2;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [ACC_W-1:0]  acc_t;

  function automatic sample_t fir_direct(
    input sample_t x, input sample_t x1, input sample_t x2, input sample_t x3,
    input coef_t b0, input coef_t b1, input coef_t b2, input coef_t b3
  );
    acc_t sum;
    sum = acc_t'(x)  * acc_t'(b0) + acc_t'(x1) * acc_t'(b1)
        + acc_t'(x2) * acc_t'(b2) + acc_t'(x3) * acc_t'(b3);
    return sum[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/lab2_fir_coef_rf.sv
// Four-entry coefficient register file: one write port, all taps readable in parallel.
module lab2_fir_coef_rf
  import lab2_fir_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_we,
  input  logic [1:0] i_addr,
  input  coef_t      i_data,
  output coef_t      o_b0,
  output coef_t      o_b1,
  output coef_t      o_b2,
  output coef_t      o_b3
);

  coef_t r_coef [NTAPS];

  // Coefficient storage, written one tap per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_coef[i] <= {COEF_W{1'b0}};
      end
    end else if (i_we) begin
      r_coef[i_addr] <= i_data;
    end
  end

  assign o_b0 = r_coef[0];
  assign o_b1 = r_coef[1];
  assign o_b2 = r_coef[2];
  assign o_b3 = r_coef[3];

endmodule

// File: rtl/lab2_fir_xpose.sv
// Transposed-form 4-tap FIR: partial sums ripple toward a single-entry
// valid/ready output stage; coefficients come from a small register file.
module lab2_fir_xpose
  import lab2_fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              coef_we,
  input  logic [1:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              clear
);

  coef_t   w_b0, w_b1, w_b2, w_b3;
  acc_t    r_s1, r_s2, r_s3;
  sample_t r_out_data;
  logic    r_out_valid;

  logic    w_in_ready;
  logic    w_accept;
  acc_t    w_p0, w_p1, w_p2, w_p3;
  acc_t    w_h1, w_h2, w_h3;
  acc_t    w_y;

  lab2_fir_coef_rf u_coef_rf (
    .clk    (clk),
    .reset  (reset),
    .i_we   (coef_we),
    .i_addr (coef_addr),
    .i_data (coef_data),
    .o_b0   (w_b0),
    .o_b1   (w_b1),
    .o_b2   (w_b2),
    .o_b3   (w_b3)
  );

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  // Products and history; clear zeroes the history seen by a same-cycle sample
  always_comb begin
    w_p0 = acc_t'(in_data) * acc_t'(w_b0);
    w_p1 = acc_t'(in_data) * acc_t'(w_b1);
    w_p2 = acc_t'(in_data) * acc_t'(w_b2);
    w_p3 = acc_t'(in_data) * acc_t'(w_b3);
    if (clear) begin
      w_h1 = {ACC_W{1'b0}};
      w_h2 = {ACC_W{1'b0}};
      w_h3 = {ACC_W{1'b0}};
    end else begin
      w_h1 = r_s1;
      w_h2 = r_s2;
      w_h3 = r_s3;
    end
    w_y = w_p0 + w_h1;
  end

  // Partial-sum chain and output stage; clear alone leaves a pending output intact
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1        <= {ACC_W{1'b0}};
      r_s2        <= {ACC_W{1'b0}};
      r_s3        <= {ACC_W{1'b0}};
      r_out_data  <= {DATA_W{1'b0}};
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1        <= w_p1 + w_h2;
      r_s2        <= w_p2 + w_h3;
      r_s3        <= w_p3;
      r_out_data  <= w_y[DATA_W-1:0];
      r_out_valid <= 1'b1;
    end else begin
      r_s1 <= w_h1;
      r_s2 <= w_h2;
      r_s3 <= w_h3;
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_lab2_fir_xpose.sv
// Directed table plus hand sequences for the transposed FIR: impulse, wrap,
// coefficient write with clear, backpressure scoreboard and mid-stream reset.
module tb_lab2_fir_xpose;
  import lab2_fir_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = 2'd0;
  logic [7:0]  coef_data = 8'h00;
  logic        clear = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lab2_fir_xpose dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .clear     (clear)
  );

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [7:0]  cdata;
    logic        clr;
    logic        vld;
    logic [15:0] x;
    logic        ordy;
    logic        exp_v;
    logic [15:0] exp_y;
  } vec_t;

  vec_t tbl [33];

  function automatic vec_t mk(input logic we, input logic [1:0] addr, input logic [7:0] cd,
                              input logic clr, input logic vld, input logic [15:0] x,
                              input logic ordy, input logic ev, input logic [15:0] ey);
    vec_t v;
    v.we = we; v.addr = addr; v.cdata = cd; v.clr = clr; v.vld = vld;
    v.x = x; v.ordy = ordy; v.exp_v = ev; v.exp_y = ey;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // backpressure scoreboard state
  logic [15:0] h1, h2, h3, exp_data, x_r;
  logic        exp_valid, exp_rdy, acc, vld_r, rdy_r;
  int          n_acc, n_cons, cyc;

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // impulse with b=1,2,3,4
    tbl[0]  = mk(1'b1, 2'd0, 8'd1,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[1]  = mk(1'b1, 2'd1, 8'd2,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[2]  = mk(1'b1, 2'd2, 8'd3,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[3]  = mk(1'b1, 2'd3, 8'd4,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[4]  = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001);
    tbl[5]  = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0002);
    tbl[6]  = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0003);
    tbl[7]  = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0004);
    tbl[8]  = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000);
    tbl[9]  = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    // wrap: all b=255, x=0xFFFF; k*0xFEFF01 mod 2^16
    tbl[10] = mk(1'b1, 2'd0, 8'd255, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[11] = mk(1'b1, 2'd1, 8'd255, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[12] = mk(1'b1, 2'd2, 8'd255, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[13] = mk(1'b1, 2'd3, 8'd255, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[14] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFF01);
    tbl[15] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFE02);
    tbl[16] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFD03);
    tbl[17] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFC04);
    // b=1,1,1,1 then clear-with-accept, b0 write, clear+accept x=5
    tbl[18] = mk(1'b1, 2'd0, 8'd1,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[19] = mk(1'b1, 2'd1, 8'd1,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[20] = mk(1'b1, 2'd2, 8'd1,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[21] = mk(1'b1, 2'd3, 8'd1,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[22] = mk(1'b0, 2'd0, 8'd0,   1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001);
    tbl[23] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 16'h0003);
    tbl[24] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 16'h0006);
    tbl[25] = mk(1'b1, 2'd0, 8'd2,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tbl[26] = mk(1'b0, 2'd0, 8'd0,   1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 16'h000A);
    tbl[27] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0007);
    tbl[28] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0006);
    tbl[29] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0006);
    tbl[30] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0001);
    // write in the same cycle as an accept: old b0=2 used, new b0=3 next
    tbl[31] = mk(1'b1, 2'd0, 8'd3,   1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 16'h0004);
    tbl[32] = mk(1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0005);

    for (int i = 0; i < 33; i++) begin
      coef_we = tbl[i].we; coef_addr = tbl[i].addr; coef_data = tbl[i].cdata;
      clear = tbl[i].clr; in_valid = tbl[i].vld; in_data = tbl[i].x;
      out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].exp_y));
    end

    // backpressure: b=1,2,3,4, clear history, random stream with scoreboard
    for (int t = 0; t < 4; t++) begin
      coef_we = 1'b1; coef_addr = 2'(t); coef_data = 8'(t + 1);
      clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
    end
    coef_we = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("bp_pre_valid", 32'(out_valid), 32'd0);
    h1 = 16'h0; h2 = 16'h0; h3 = 16'h0; exp_data = 16'h0; exp_valid = 1'b0;
    n_acc = 0; n_cons = 0; cyc = 0;
    while (n_acc < 10 && cyc < 200) begin
      vld_r = 1'($urandom_range(0, 1));
      rdy_r = 1'($urandom_range(0, 1));
      x_r   = 16'($urandom);
      in_valid = vld_r; out_ready = rdy_r; in_data = x_r;
      #1;
      exp_rdy = !exp_valid || rdy_r;
      chk("bp_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (out_valid && out_ready) n_cons++;
      acc = vld_r && exp_rdy;
      tick();
      if (acc) begin
        exp_data  = fir_direct(x_r, h1, h2, h3, 8'd1, 8'd2, 8'd3, 8'd4);
        exp_valid = 1'b1;
        h3 = h2; h2 = h1; h1 = x_r;
        n_acc++;
      end else if (rdy_r) begin
        exp_valid = 1'b0;
      end
      chk("bp_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) chk("bp_data", 32'(out_data), 32'(exp_data));
      cyc++;
    end
    if (cyc >= 200) chk("bp_timeout", 32'(n_acc), 32'd10);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    if (out_valid && out_ready) n_cons++;
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_consumed", 32'(n_cons), 32'(n_acc));

    // reset mid-stream with a pending output, coef write and accept asserted
    in_valid = 1'b1; in_data = 16'h0007; out_ready = 1'b0;
    tick();
    chk("rm_valid", 32'(out_valid), 32'd1);
    chk("rm_stall_rdy", 32'(in_ready), 32'd0);
    reset = 1'b1; coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd5;
    tick();
    chk("rm_rst_valid", 32'(out_valid), 32'd0);
    chk("rm_rst_data", 32'(out_data), 32'd0);
    chk("rm_rst_rdy", 32'(in_ready), 32'd1);
    reset = 1'b0; coef_we = 1'b0; in_data = 16'h0009; out_ready = 1'b1;
    tick();
    chk("rm_post_valid", 32'(out_valid), 32'd1);
    chk("rm_post_data", 32'(out_data), 32'd0);
    in_valid = 1'b0; coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd1;
    tick();
    coef_we = 1'b0; in_valid = 1'b1; in_data = 16'h0003;
    tick();
    chk("rm_b0_data", 32'(out_data), 32'd3);
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
